// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Brief    : Shared defaults and width helper for the serial pattern detector.
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

    localparam int              PAT_LEN_DEF = 4;
    localparam logic [3:0]      PAT_RST_DEF = 4'b1011;
    localparam int              CNT_W_DEF   = 8;
    localparam int              FILL_W_DEF  = $clog2(PAT_LEN_DEF);

    // Fill counter must reach PAT_LEN-1.
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_hist_shreg.sv
`default_nettype none
// ============================================================================
// Module   : seq_hist_shreg
// Brief    : PAT_LEN-1 bit history shift register with saturating fill count.
// Revision : 1.0 - initial release
// ============================================================================
module seq_hist_shreg
    import seq_detect_pkg::*;
#(
    parameter int PAT_LEN = PAT_LEN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift,
    input  logic               din,
    input  logic               flush,
    output logic [PAT_LEN-2:0] hist,
    output logic               full
);

    localparam int                 c_FILL_W   = fill_w(PAT_LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0]  r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic [PAT_LEN-2:0]  w_hist_next;
    logic                w_full;

    generate
        if (PAT_LEN == 2) begin : g_hist_one
            assign w_hist_next = din;
        end else begin : g_hist_multi
            assign w_hist_next = {r_hist[PAT_LEN-3:0], din};
        end
    endgenerate

    assign w_full = (r_fill == c_FILL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else if (shift) begin
            r_hist <= w_hist_next;
        end
    end

    // Flush wins over shift so a consumed match cannot seed the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (flush) begin
            r_fill <= '0;
        end else if (shift && !w_full) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    assign hist = r_hist;
    assign full = w_full;

endmodule
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_param
// Brief    : Programmable Mealy serial-pattern detector with match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_RST_DEF,
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               seen
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [PAT_LEN-1:0] r_pat;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               r_seen;
    logic [PAT_LEN-2:0] w_hist;
    logic               w_full;
    logic               w_shift;
    logic               w_flush;
    logic               w_match;

    assign w_shift = x_valid & ~cfg_load;
    assign w_match = w_shift & w_full & ({w_hist, x} == r_pat);
    assign w_flush = cfg_load | (w_match & ~overlap);

    seq_hist_shreg #(
        .PAT_LEN (PAT_LEN)
    ) u_hist (
        .clk   (clk),
        .rst   (rst),
        .shift (w_shift),
        .din   (x),
        .flush (w_flush),
        .hist  (w_hist),
        .full  (w_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat <= PAT_RST;
        end else if (cfg_load) begin
            r_pat <= cfg_pattern;
        end
    end

    // A clear in the same cycle as a match drops that match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_cnt <= '0;
            r_seen      <= 1'b0;
        end else if (cnt_clr) begin
            r_match_cnt <= '0;
            r_seen      <= 1'b0;
        end else if (w_match) begin
            if (r_match_cnt != c_CNT_MAX) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
            r_seen <= 1'b1;
        end
    end

    assign y         = w_match;
    assign match_cnt = r_match_cnt;
    assign seen      = r_seen;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_param
// Brief    : Directed self-checking bench for seq_detect_param (CNT_W = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       x;
    logic       x_valid;
    logic       overlap;
    logic       cfg_load;
    logic [3:0] cfg_pattern;
    logic       cnt_clr;
    logic       y;
    logic [1:0] match_cnt;
    logic       seen;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_detect_param #(
        .PAT_LEN (4),
        .PAT_RST (4'b1011),
        .CNT_W   (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .x_valid     (x_valid),
        .overlap     (overlap),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cnt_clr     (cnt_clr),
        .y           (y),
        .match_cnt   (match_cnt),
        .seen        (seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_y(input logic exp, input string tag);
        n_cmp++;
        assert (y === exp) else begin
            n_fail++;
            $error("FAIL %s: y observed %b expected %b", tag, y, exp);
        end
    endtask

    task automatic chk_cnt(input logic [1:0] exp_cnt, input logic exp_seen, input string tag);
        n_cmp++;
        assert (match_cnt === exp_cnt) else begin
            n_fail++;
            $error("FAIL %s: match_cnt observed %0d expected %0d", tag, match_cnt, exp_cnt);
        end
        n_cmp++;
        assert (seen === exp_seen) else begin
            n_fail++;
            $error("FAIL %s: seen observed %b expected %b", tag, seen, exp_seen);
        end
    endtask

    // Drive one cycle just after a rising edge, check y mid-cycle, then advance.
    task automatic step(input logic v, input logic xb, input logic clr,
                        input logic exp_y, input string tag);
        x_valid = v;
        x       = xb;
        cnt_clr = clr;
        #2;
        chk_y(exp_y, tag);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic load_clr(input logic [3:0] pat);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cnt_clr     = 1'b1;
        x_valid     = 1'b0;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; overlap = 1'b1;
        cfg_load = 1'b0; cfg_pattern = 4'b0000; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_y(1'b0, "reset_y");
        chk_cnt(2'd0, 1'b0, "reset_cnt");
        rst = 1'b0;

        // Overlapping: 1011011 -> hits on bits 4 and 7
        overlap = 1'b1;
        step(1, 1, 0, 0, "ov_b1"); step(1, 0, 0, 0, "ov_b2");
        step(1, 1, 0, 0, "ov_b3"); step(1, 1, 0, 1, "ov_b4");
        step(1, 0, 0, 0, "ov_b5"); step(1, 1, 0, 0, "ov_b6");
        step(1, 1, 0, 1, "ov_b7");
        chk_cnt(2'd2, 1'b1, "ov_cnt");

        // Non-overlapping: same stream -> only bit 4
        load_clr(4'b1011);
        chk_cnt(2'd0, 1'b0, "clr_cnt");
        overlap = 1'b0;
        step(1, 1, 0, 0, "no_b1"); step(1, 0, 0, 0, "no_b2");
        step(1, 1, 0, 0, "no_b3"); step(1, 1, 0, 1, "no_b4");
        step(1, 0, 0, 0, "no_b5"); step(1, 1, 0, 0, "no_b6");
        step(1, 1, 0, 0, "no_b7");
        chk_cnt(2'd1, 1'b1, "no_cnt");

        // Gaps between bits 2 and 3
        load_clr(4'b1011);
        step(1, 1, 0, 0, "gap_b1"); step(1, 0, 0, 0, "gap_b2");
        step(0, 1, 0, 0, "gap_i1"); step(0, 1, 0, 0, "gap_i2");
        step(0, 1, 0, 0, "gap_i3");
        step(1, 1, 0, 0, "gap_b3"); step(1, 1, 0, 1, "gap_b4");
        chk_cnt(2'd1, 1'b1, "gap_cnt");

        // cfg_load mid-stream: the concurrent valid bit would match the old pattern
        load_clr(4'b1011);
        step(1, 1, 0, 0, "cfg_b1"); step(1, 0, 0, 0, "cfg_b2");
        step(1, 1, 0, 0, "cfg_b3");
        cfg_load = 1'b1; cfg_pattern = 4'b0110;
        step(1, 1, 0, 0, "cfg_load_cycle");
        cfg_load = 1'b0;
        step(1, 0, 0, 0, "cfg_n1"); step(1, 1, 0, 0, "cfg_n2");
        step(1, 1, 0, 0, "cfg_n3"); step(1, 0, 0, 1, "cfg_n4");
        chk_cnt(2'd1, 1'b1, "cfg_cnt");

        // Saturation at 3, then clear beats a simultaneous 6th match
        load_clr(4'b1011);
        overlap = 1'b1;
        step(1, 1, 0, 0, "sat_a1"); step(1, 0, 0, 0, "sat_a2");
        step(1, 1, 0, 0, "sat_a3"); step(1, 1, 0, 1, "sat_m1");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, "sat_z"); step(1, 1, 0, 0, "sat_o");
            step(1, 1, 0, 1, "sat_m");
        end
        chk_cnt(2'd3, 1'b1, "sat_cnt");
        step(1, 0, 0, 0, "clr_z"); step(1, 1, 0, 0, "clr_o");
        step(1, 1, 1, 1, "clr_m6");
        chk_cnt(2'd0, 1'b0, "clr_pri");

        // Reset mid-stream after a counted match and a partial 101
        load_clr(4'b1011);
        overlap = 1'b0;
        step(1, 1, 0, 0, "rs_a1"); step(1, 0, 0, 0, "rs_a2");
        step(1, 1, 0, 0, "rs_a3"); step(1, 1, 0, 1, "rs_a4");
        step(1, 1, 0, 0, "rs_p1"); step(1, 0, 0, 0, "rs_p2");
        step(1, 1, 0, 0, "rs_p3");
        chk_cnt(2'd1, 1'b1, "rs_pre");
        rst = 1'b1; x = 1'b1; x_valid = 1'b1;
        #2;
        chk_y(1'b0, "rs_during_y");
        chk_cnt(2'd0, 1'b0, "rs_during_cnt");
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        rst = 1'b0;
        step(1, 1, 0, 0, "rs_lone1");
        step(1, 1, 0, 0, "rs_f1"); step(1, 0, 0, 0, "rs_f2");
        step(1, 1, 0, 0, "rs_f3"); step(1, 1, 0, 1, "rs_f4");
        chk_cnt(2'd1, 1'b1, "rs_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised Mealy serial-pattern detector. It replaces the fixed two-flip-flop detector with a runtime-programmable pattern of PAT_LEN bits and the following additions:
- a qualified input strobe;
- selectable overlapping or non-overlapping detection;
- a saturating match counter.

It sits on a single-bit serial stream and flags the pattern in the same cycle as the final bit arrives.

## Interface
Parameters:
- PAT_LEN, 4: pattern length in bits; legal range 2..32.
- PAT_RST, 4'b1011: pattern loaded at reset; PAT_LEN bits wide; MSB is the first bit expected.
- CNT_W, 8: match-counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is consumed this cycle.
- overlap  in  1  1 = overlapping detection; 0 = non-overlapping. Sampled every valid cycle.
- cfg_load  in  1  load cfg_pattern into the pattern register.
- cfg_pattern  in  PAT_LEN  new pattern, MSB first.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  Mealy match output; combinational.
- match_cnt  out  CNT_W  number of matches, saturating.
- seen  out  1  sticky flag; set on the first match since reset or cnt_clr.

## Operation
- **State registers:**
  - pat_q (PAT_LEN bits);
  - hist_q (PAT_LEN-1 bits, newest bit in the LSB);
  - fill_q (count of valid bits held, 0..PAT_LEN-1, saturates at PAT_LEN-1);
  - match_cnt;
  - seen.
- **Window:** {hist_q, x}.
- **Match:** y = x_valid & ~cfg_load & (fill_q == PAT_LEN-1) & ({hist_q, x} == pat_q).
- **Valid cycle** (x_valid=1, cfg_load=0):
  - hist_q shifts left, taking x into the LSB;
  - fill_q increments, saturating.
- **On y=1 with overlap=0:** fill_q goes to 0 instead, so the matched bits cannot start the next match.
- **On y=1 with overlap=1:** fill_q stays at PAT_LEN-1.
- **Idle cycle** (x_valid=0): hist_q and fill_q hold; y=0.
- **cfg_load=1:**
  - pat_q <= cfg_pattern;
  - fill_q <= 0;
  - any x_valid in the same cycle is discarded, and y is forced to 0.
- **Counter:**
  - on y=1, match_cnt increments, saturating at 2^CNT_W-1;
  - seen <= 1.
- **cnt_clr=1:** match_cnt <= 0 and seen <= 0. A clear beats a simultaneous match, and that match is not counted.
- **Reset values:**
  - pat_q = PAT_RST;
  - hist_q = 0;
  - fill_q = 0;
  - match_cnt = 0;
  - seen = 0;
  - y = 0 (fill_q is 0 during reset).

## Timing
- Latency from the final pattern bit to y is zero cycles: y is combinational from x, x_valid and the registers.
- match_cnt and seen update on the edge that closes the match cycle, so they are visible one cycle after y.
- A new pattern applies to bits presented from the cycle after cfg_load.
- The first possible match after cfg_load, after reset, or after a non-overlapping match comes on the PAT_LEN-th subsequent valid bit.
- Gaps in x_valid are transparent: matching depends only on the sequence of valid bits.
- Asserting rst mid-stream discards partial history immediately. No match can fire until PAT_LEN valid bits follow the release of rst.
- overlap may change between bits. It affects only the fill_q update in the cycle where y=1.

## Structure
- **Shared package seq_detect_pkg:**
  - default constants PAT_LEN_DEF=4, PAT_RST_DEF=4'b1011, CNT_W_DEF=8;
  - a fill-counter width constant computed as $clog2(PAT_LEN).
- **One sub-module, seq_hist_shreg:** the PAT_LEN-1 bit history shift register plus fill counter. It has inputs shift, din and flush, and outputs hist and full, with an async active-high reset.
- **Top level:** pattern register, comparator, Mealy output, counter and sticky logic.

## Test plan
- **Overlap=1, pattern 1011, valid stream 1,0,1,1,0,1,1:** y=1 on bits 4 and 7; match_cnt=2; seen=1.
- **Same stream, overlap=0:** y=1 on bit 4 only; match_cnt=1.
- **Gaps:** x_valid deasserted for 3 cycles between bits 2 and 3 of 1011 → y=1 on the 4th valid bit; y=0 during the gaps.
- **cfg_load mid-stream:** cfg_load with cfg_pattern=4'b0110 after bits 1,0,1 → those bits are discarded; stream 0,1,1,0 then gives y=1 on its 4th bit; the old pattern never fires.
- **Saturation and clear priority, CNT_W=2:** 5 matches → match_cnt=3. Then cnt_clr in the same cycle as a 6th match → match_cnt=0 and seen=0.
- **Reset mid-stream:** rst asserted after bits 1,0,1 → all outputs 0; the following bit 1 alone gives y=0; a full 1011 afterwards gives y=1.
